// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared types and constants for the 4x1 mux round-robin sequencer.
//   seq_state_t : sequencer FSM states (IDLE, SELECT, CAPTURE, OUTPUT)
//   S0..S3      : mux select codes for channels 0..3
//   NUM_CH      : number of request channels / mux inputs
//   nextPtr     : round-robin pointer advance (wraps 3 -> 0)
// ---------------------------------------------------------------------------
package mux_pkg;

   localparam int NUM_CH = 4;

   localparam logic [1:0] S0 = 2'b00;
   localparam logic [1:0] S1 = 2'b01;
   localparam logic [1:0] S2 = 2'b10;
   localparam logic [1:0] S3 = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SELECT  = 2'd1,
      CAPTURE = 2'd2,
      OUTPUT  = 2'd3
   } seq_state_t;

   // The channel just served drops to lowest priority; the 2-bit add wraps 3 -> 0.
   function automatic logic [1:0] nextPtr(input logic [1:0] sel);
      return sel + 2'd1;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational 4-way arbiter pick.
// Config macro: MUX_SEQ_FIXED_PRIO_EN
//   undefined : round-robin, search starts at ptr_i and wraps modulo 4
//   defined   : fixed priority, channel 0 highest, ptr_i ignored
// Ports:
//   req_i    in  4  per-channel request
//   ptr_i    in  2  channel holding highest priority this round
//   winner_o out 2  selected channel (S0 when no request)
//   any_o    out 1  at least one request present
// ---------------------------------------------------------------------------
module rr_pick4
   import mux_pkg::*;
(
   input  logic [NUM_CH-1:0] req_i,
   input  logic [1:0]        ptr_i,
   output logic [1:0]        winner_o,
   output logic              any_o
);

`ifdef MUX_SEQ_FIXED_PRIO_EN
   // Scan from the lowest priority upward so the highest-priority requester
   // is the last one written and therefore wins.
   always_comb begin
      winner_o = S0;
      any_o    = |req_i;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req_i[i]) winner_o = 2'(i);
      end
   end
`else
   logic [1:0] cand;

   // Same scan-and-overwrite trick, but over channel offsets from ptr_i: the
   // smallest offset (closest to ptr_i going upward, wrapping) wins.
   always_comb begin
      winner_o = S0;
      any_o    = |req_i;
      cand     = ptr_i;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         cand = ptr_i + 2'(i);
         if (req_i[cand]) winner_o = cand;
      end
   end
`endif

endmodule

// File: rtl/mux4_rr_sequencer.sv
// ---------------------------------------------------------------------------
// mux4_rr_sequencer
// Control stage in front of an external 4x1 data mux. Arbitrates four request
// channels, drives the mux select, gives the mux one settle cycle, captures the
// muxed word and presents it downstream with a valid/ready handshake.
// Config macro: MUX_SEQ_FIXED_PRIO_EN (fixed priority, ch0 highest; pointer
// held at 0 and RST_PTR ignored). Default build is round-robin.
// Parameters:
//   DATA_W   width of the mux data / captured word
//   RST_PTR  channel with highest priority after reset
// Ports:
//   clk_i        in  1       clock, rising edge
//   rst_i        in  1       synchronous active-high reset
//   req_i        in  4       per-channel request
//   grant_o      out 4       one-hot pulse in the first OUTPUT cycle
//   Sel_o        out 2       registered mux select
//   mux_data_i   in  DATA_W  mux output fed back
//   out_data_o   out DATA_W  captured word
//   out_ch_o     out 2       channel the captured word came from
//   out_valid_o  out 1       out_data_o/out_ch_o valid
//   out_ready_i  in  1       downstream accept
// ---------------------------------------------------------------------------
module mux4_rr_sequencer
   import mux_pkg::*;
#(
   parameter int         DATA_W  = 4,
   parameter logic [1:0] RST_PTR = 2'd0
)
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_CH-1:0] req_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic [1:0]        Sel_o,
   input  logic [DATA_W-1:0] mux_data_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        out_ch_o,
   output logic              out_valid_o,
   input  logic              out_ready_i
);

`ifdef MUX_SEQ_FIXED_PRIO_EN
   localparam logic [1:0] PTR_INIT = 2'd0;
`else
   localparam logic [1:0] PTR_INIT = RST_PTR;
`endif

   seq_state_t        state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [NUM_CH-1:0] grant_q, grant_d;
   logic [DATA_W-1:0] outData_q, outData_d;
   logic [1:0]        outCh_q, outCh_d;
   logic              outValid_q, outValid_d;

   logic [1:0]        winner;
   logic              anyReq;

   rr_pick4 u_pick (
      .req_i    (req_i),
      .ptr_i    (ptr_q),
      .winner_o (winner),
      .any_o    (anyReq)
   );

   // State and output registers. Reset drops any in-flight or held word.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         sel_q      <= S0;
         ptr_q      <= PTR_INIT;
         grant_q    <= '0;
         outData_q  <= '0;
         outCh_q    <= S0;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         outData_q  <= outData_d;
         outCh_q    <= outCh_d;
         outValid_q <= outValid_d;
      end
   end

   // Next-state logic. Sel only moves in IDLE, so it stays fixed from the
   // arbitration edge through capture and while the word waits downstream.
   // Grant defaults low so it is a single-cycle pulse after the capture edge.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      ptr_d      = ptr_q;
      grant_d    = '0;
      outData_d  = outData_q;
      outCh_d    = outCh_q;
      outValid_d = outValid_q;

      unique case (state_q)
         IDLE: begin
            if (anyReq) begin
               sel_d   = winner;
               state_d = SELECT;
            end
         end
         SELECT: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            outData_d      = mux_data_i;
            outCh_d        = sel_q;
            outValid_d     = 1'b1;
            grant_d[sel_q] = 1'b1;
`ifndef MUX_SEQ_FIXED_PRIO_EN
            ptr_d          = nextPtr(sel_q);
`endif
            state_d        = OUTPUT;
         end
         OUTPUT: begin
            if (out_ready_i) begin
               outValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign grant_o     = grant_q;
   assign Sel_o       = sel_q;
   assign out_data_o  = outData_q;
   assign out_ch_o    = outCh_q;
   assign out_valid_o = outValid_q;

endmodule

// File: tb/tb_mux4_rr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_sequencer
// Self-checking bench for mux4_rr_sequencer. Models the external 4x1 mux and
// keeps a transaction-level reference: a request is arbitrated, the word is
// captured two edges later, then held until downstream accepts it.
// Honours MUX_SEQ_FIXED_PRIO_EN the same way as the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux4_rr_sequencer;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] sel;
   logic [3:0] muxData;
   logic [3:0] outData;
   logic [1:0] outCh;
   logic       outValid;
   logic       outReady;

   logic [3:0] inWord [4];

   int checks = 0;
   int errors = 0;

   // Reference model state (transaction view).
   int         mPtr;
   int         mAge;
   logic [1:0] mSel;
   logic [3:0] mGrant;
   logic [3:0] mData;
   logic [1:0] mCh;
   logic       mValid;

   int dutServed[$];

   mux4_rr_sequencer #(.DATA_W(4), .RST_PTR(2'd0)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .grant_o     (grant),
      .Sel_o       (sel),
      .mux_data_i  (muxData),
      .out_data_o  (outData),
      .out_ch_o    (outCh),
      .out_valid_o (outValid),
      .out_ready_i (outReady)
   );

   // External 4x1 mux steered by the sequencer.
   assign muxData = inWord[sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int ptr);
      int c;
`ifdef MUX_SEQ_FIXED_PRIO_EN
      ptr = 0;
`endif
      for (int i = 0; i < 4; i++) begin
         c = (ptr + i) % 4;
         if (r[c]) return c;
      end
      return 0;
   endfunction

   // One rising edge of the reference. mAge counts edges since arbitration:
   // -1 free, 0 just arbitrated, 1 settling, >=2 word held downstream.
   task automatic modelStep();
      int w;
      if (rst) begin
         mPtr = 0; mAge = -1; mSel = 2'd0; mGrant = 4'd0;
         mData = 4'd0; mCh = 2'd0; mValid = 1'b0;
      end else begin
         mGrant = 4'd0;
         if (mAge < 0) begin
            if (req != 4'd0) begin
               w = pick(req, mPtr);
               mSel = 2'(w);
               mAge = 0;
            end
         end else if (mAge == 0) begin
            mAge = 1;
         end else if (mAge == 1) begin
            mData  = inWord[mSel];
            mCh    = mSel;
            mValid = 1'b1;
            mGrant = 4'd1 << mSel;
`ifndef MUX_SEQ_FIXED_PRIO_EN
            mPtr   = (int'(mSel) + 1) % 4;
`endif
            mAge   = 2;
         end else if (outReady) begin
            mValid = 1'b0;
            mAge   = -1;
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model on the edge, check at negedge.
   task automatic applyStimulus(input logic [3:0] r, input logic rdy, input logic rs);
      req      = r;
      outReady = rdy;
      rst      = rs;
      if (outValid && rdy && !rs) dutServed.push_back(int'(outCh));
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput("sel", 32'(sel), 32'(mSel));
      checkOutput("grant", 32'(grant), 32'(mGrant));
      checkOutput("valid", 32'(outValid), 32'(mValid));
      if (mValid) begin
         checkOutput("data", 32'(outData), 32'(mData));
         checkOutput("ch", 32'(outCh), 32'(mCh));
      end
   endtask

   int expCh;

   initial begin
      req = 4'd0; outReady = 1'b0; rst = 1'b1;
      for (int k = 0; k < 4; k++) inWord[k] = 4'(k + 5);

      // Reset state.
      applyStimulus(4'd0, 1'b0, 1'b1);
      applyStimulus(4'd0, 1'b0, 1'b1);
      checkOutput("rstValid", 32'(outValid), 32'd0);
      checkOutput("rstSel", 32'(sel), 32'd0);

      // Single request on ch2, word 4'hA.
      inWord[2] = 4'hA;
      applyStimulus(4'b0100, 1'b1, 1'b0);
      checkOutput("t2Sel", 32'(sel), 32'd2);
      applyStimulus(4'b0100, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("t2Data", 32'(outData), 32'hA);
      checkOutput("t2Grant", 32'(grant), 32'b0100);
      for (int k = 0; k < 3; k++) applyStimulus(4'd0, 1'b1, 1'b0);

      // All channels requesting from reset: fair rotation, data k+5.
      inWord[2] = 4'd7;
      applyStimulus(4'd0, 1'b1, 1'b1);
      dutServed.delete();
      for (int k = 0; k < 22; k++) applyStimulus(4'hF, 1'b1, 1'b0);
      checkOutput("rrCount", 32'(dutServed.size() >= 5), 32'd1);
      for (int k = 0; k < 5 && k < dutServed.size(); k++) begin
`ifdef MUX_SEQ_FIXED_PRIO_EN
         expCh = 0;
`else
         expCh = k % 4;
`endif
         checkOutput("rrOrder", 32'(dutServed[k]), 32'(expCh));
      end

      // Back-pressure for 10+ cycles, then a single release.
      applyStimulus(4'd0, 1'b1, 1'b1);
      dutServed.delete();
      applyStimulus(4'b0010, 1'b0, 1'b0);
      for (int k = 0; k < 13; k++) applyStimulus(4'b0010, 1'b0, 1'b0);
      checkOutput("bpHeldData", 32'(outData), 32'd6);
      checkOutput("bpHeldValid", 32'(outValid), 32'd1);
      applyStimulus(4'd0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) applyStimulus(4'd0, 1'b1, 1'b0);
      checkOutput("bpOneXfer", 32'(dutServed.size()), 32'd1);

      // Pointer wrap: ch3 served, then ch0 wins over ch3.
      applyStimulus(4'b1000, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) applyStimulus(4'd0, 1'b1, 1'b0);
      dutServed.delete();
      for (int k = 0; k < 6; k++) applyStimulus(4'b1001, 1'b1, 1'b0);
      checkOutput("wrapFirst", 32'(dutServed.size() > 0 ? dutServed[0] : 99), 32'd0);

      // Reset while a word is held.
      applyStimulus(4'b0001, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) applyStimulus(4'd0, 1'b0, 1'b0);
      checkOutput("preRstValid", 32'(outValid), 32'd1);
      applyStimulus(4'd0, 1'b0, 1'b1);
      checkOutput("postRstValid", 32'(outValid), 32'd0);
      checkOutput("postRstGrant", 32'(grant), 32'd0);
      checkOutput("postRstSel", 32'(sel), 32'd0);

      // Randomized traffic with occasional resets and changing mux inputs.
      for (int k = 0; k < 400; k++) begin
         for (int j = 0; j < 4; j++) inWord[j] = 4'($urandom_range(0, 15));
         applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 60) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
